// File: rtl/hack_pkg.sv
// Shared types for the Hack data-RAM arbiter slice.
// Holds the default widths, the owner tag and the request bundle.
package hack_pkg;

   localparam int HACK_ADDR_W = 15;
   localparam int HACK_DATA_W = 16;

   typedef logic [HACK_ADDR_W-1:0] addr_t;
   typedef logic [HACK_DATA_W-1:0] word_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   typedef struct packed {
      addr_t addr;
      logic  we;
      word_t wdata;
   } req_t;

endpackage

// File: rtl/hack_ram_if.sv
// One requester port of the Hack RAM arbiter.
// master: requester side (valid/req out, ready/rsp in); slave: arbiter side.
interface hack_ram_if;
   import hack_pkg::*;

   logic  valid;
   logic  ready;
   req_t  req;
   logic  rsp_valid;
   word_t rsp_rdata;

   modport master (
      output valid, req,
      input  ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  valid, req,
      output ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/hack_rr_starve_ctr.sv
// Saturating wait counter with a starve flag for a low-priority requester.
// Ports: clk, reset, req_valid, grant in; starve out (wait_cnt == MAX_WAIT).
module hack_rr_starve_ctr #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req_valid,
   input  logic grant,
   output logic starve
);

   localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!req_valid || grant) begin
         wait_cnt <= '0;
      end else if (wait_cnt != LIMIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   assign starve = (wait_cnt == LIMIT);

endmodule

// File: rtl/hack_ram_arbiter.sv
// Two-port arbiter in front of the single-port Hack data RAM.
// Ports: clk, reset; port0 (CPU, high priority) and port1 (screen/DMA,
// bounded starvation) as hack_ram_if slaves; mem_addr/mem_load/mem_in out
// to the RAM, mem_out in (data for the address of the previous cycle).
module hack_ram_arbiter
   import hack_pkg::*;
#(
   parameter int ADDR_W   = HACK_ADDR_W,
   parameter int DATA_W   = HACK_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   hack_ram_if.slave         port0,
   hack_ram_if.slave         port1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_load,
   output logic [DATA_W-1:0] mem_in,
   input  logic [DATA_W-1:0] mem_out
);

   logic              gnt0;
   logic              gnt1;
   logic              gnt;
   logic              starve;
   req_t              sel;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] in_q;
   logic              pend_q;
   owner_e            owner_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              rsp0_valid;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp0_rdata;
   logic [DATA_W-1:0] rsp1_rdata;

   hack_rr_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .req_valid (port1.valid),
      .grant     (gnt1),
      .starve    (starve)
   );

   // Overlapping conditions are intentional: first match wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         priority case (1'b1)
            starve && port1.valid: gnt1 = 1'b1;
            port0.valid:           gnt0 = 1'b1;
            port1.valid:           gnt1 = 1'b1;
            default:               ;
         endcase
      end
   end

   assign gnt = gnt0 | gnt1;
   assign sel = gnt1 ? port1.req : port0.req;

   assign port0.ready = gnt0;
   assign port1.ready = gnt1;

   // Idle cycles replay the last address/data so the bus never floats.
   always_comb begin
      mem_load = gnt & sel.we;
      mem_addr = addr_q;
      mem_in   = in_q;
      if (reset) begin
         mem_addr = '0;
         mem_in   = '0;
      end else if (gnt) begin
         mem_addr = sel.addr;
         mem_in   = sel.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         in_q   <= '0;
      end else if (gnt) begin
         addr_q <= sel.addr;
         in_q   <= sel.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q   <= 1'b0;
         owner_q  <= OWN_CPU;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         pend_q   <= gnt & ~sel.we;
         owner_q  <= gnt1 ? OWN_DMA : OWN_CPU;
         rdata0_q <= rsp0_rdata;
         rdata1_q <= rsp1_rdata;
      end
   end

   // Non-owner rdata keeps its last value; rsp_valid qualifies it.
   always_comb begin
      rsp0_valid = ~reset & pend_q & (owner_q == OWN_CPU);
      rsp1_valid = ~reset & pend_q & (owner_q == OWN_DMA);
      rsp0_rdata = rsp0_valid ? mem_out : rdata0_q;
      rsp1_rdata = rsp1_valid ? mem_out : rdata1_q;
      if (reset) begin
         rsp0_rdata = '0;
         rsp1_rdata = '0;
      end
   end

   assign port0.rsp_valid = rsp0_valid;
   assign port0.rsp_rdata = rsp0_rdata;
   assign port1.rsp_valid = rsp1_valid;
   assign port1.rsp_rdata = rsp1_rdata;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a behavioural Hack RAM model.
// Inputs change 1 time unit after the rising edge; outputs checked there too.
module tb_hack_ram_arbiter;
   import hack_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] mem_addr;
   logic        mem_load;
   logic [15:0] mem_in;
   logic [15:0] mem_out;
   logic [15:0] ram [0:32767];

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   hack_ram_if if0 ();
   hack_ram_if if1 ();

   hack_ram_arbiter #(
      .ADDR_W   (15),
      .DATA_W   (16),
      .MAX_WAIT (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .port0    (if0),
      .port1    (if1),
      .mem_addr (mem_addr),
      .mem_load (mem_load),
      .mem_in   (mem_in),
      .mem_out  (mem_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_load) ram[mem_addr] <= mem_in;
      mem_out <= ram[mem_addr];
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic v, input logic we,
                       input logic [14:0] a, input logic [15:0] d);
      if0.valid     = v;
      if0.req.we    = we;
      if0.req.addr  = a;
      if0.req.wdata = d;
   endtask

   task automatic drv1(input logic v, input logic we,
                       input logic [14:0] a, input logic [15:0] d);
      if1.valid     = v;
      if1.req.we    = we;
      if1.req.addr  = a;
      if1.req.wdata = d;
   endtask

   task automatic no_rsp(input string tag);
      chk({tag, "_rv0"}, 32'(if0.rsp_valid), 32'd0);
      chk({tag, "_rv1"}, 32'(if1.rsp_valid), 32'd0);
   endtask

   // Both ports write continuously; port 1 must win every fifth cycle.
   task automatic contend(input int n, input string tag);
      logic g1;
      drv0(1'b1, 1'b1, 15'h0010, 16'h1111);
      drv1(1'b1, 1'b1, 15'h4000, 16'h2222);
      for (int i = 0; i < n; i++) begin
         #1;
         g1 = (i % 5 == 4);
         chk($sformatf("%s_rdy0_%0d", tag, i), 32'(if0.ready), 32'(!g1));
         chk($sformatf("%s_rdy1_%0d", tag, i), 32'(if1.ready), 32'(g1));
         chk($sformatf("%s_ld_%0d", tag, i), 32'(mem_load), 32'd1);
         chk($sformatf("%s_addr_%0d", tag, i), 32'(mem_addr),
             g1 ? 32'h4000 : 32'h0010);
         chk($sformatf("%s_in_%0d", tag, i), 32'(mem_in),
             g1 ? 32'h2222 : 32'h1111);
         no_rsp($sformatf("%s_%0d", tag, i));
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drv0(1'b1, 1'b0, 15'h0010, 16'h0000);
      drv1(1'b1, 1'b0, 15'h4000, 16'h0000);
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rst_rdy0_%0d", i), 32'(if0.ready), 32'd0);
         chk($sformatf("rst_rdy1_%0d", i), 32'(if1.ready), 32'd0);
         chk($sformatf("rst_ld_%0d", i), 32'(mem_load), 32'd0);
         chk($sformatf("rst_addr_%0d", i), 32'(mem_addr), 32'd0);
         chk($sformatf("rst_in_%0d", i), 32'(mem_in), 32'd0);
         chk($sformatf("rst_rd0_%0d", i), 32'(if0.rsp_rdata), 32'd0);
         no_rsp($sformatf("rst_%0d", i));
      end

      reset = 1'b0;
      contend(10, "starve");

      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      drv1(1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      chk("idle_rdy0", 32'(if0.ready), 32'd0);
      chk("idle_rdy1", 32'(if1.ready), 32'd0);
      chk("idle_ld", 32'(mem_load), 32'd0);
      chk("idle_addr_hold", 32'(mem_addr), 32'h4000);
      chk("idle_in_hold", 32'(mem_in), 32'h2222);
      step();

      drv0(1'b1, 1'b1, 15'h0010, 16'h1234);
      #1;
      chk("raw_c1_rdy0", 32'(if0.ready), 32'd1);
      chk("raw_c1_ld", 32'(mem_load), 32'd1);
      chk("raw_c1_in", 32'(mem_in), 32'h1234);
      no_rsp("raw_c1");
      step();
      drv0(1'b1, 1'b0, 15'h0010, 16'h0000);
      #1;
      chk("raw_c2_rdy0", 32'(if0.ready), 32'd1);
      chk("raw_c2_ld", 32'(mem_load), 32'd0);
      no_rsp("raw_c2");
      step();
      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      chk("raw_c3_rv0", 32'(if0.rsp_valid), 32'd1);
      chk("raw_c3_rd0", 32'(if0.rsp_rdata), 32'h1234);
      chk("raw_c3_rv1", 32'(if1.rsp_valid), 32'd0);
      step();
      no_rsp("raw_c4");
      chk("raw_c4_rd0_hold", 32'(if0.rsp_rdata), 32'h1234);

      drv0(1'b1, 1'b1, 15'h0001, 16'hAAAA);
      step();
      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      drv1(1'b1, 1'b1, 15'h4000, 16'h5555);
      #1;
      chk("pre_rdy1", 32'(if1.ready), 32'd1);
      step();

      drv1(1'b0, 1'b0, 15'h0000, 16'h0000);
      drv0(1'b1, 1'b0, 15'h0001, 16'h0000);
      #1;
      chk("alt_c1_rdy0", 32'(if0.ready), 32'd1);
      step();
      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      drv1(1'b1, 1'b0, 15'h4000, 16'h0000);
      #1;
      chk("alt_c2_rdy1", 32'(if1.ready), 32'd1);
      chk("alt_c2_rv0", 32'(if0.rsp_valid), 32'd1);
      chk("alt_c2_rd0", 32'(if0.rsp_rdata), 32'hAAAA);
      chk("alt_c2_rv1", 32'(if1.rsp_valid), 32'd0);
      step();
      drv1(1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      chk("alt_c3_rv1", 32'(if1.rsp_valid), 32'd1);
      chk("alt_c3_rd1", 32'(if1.rsp_rdata), 32'h5555);
      chk("alt_c3_rv0", 32'(if0.rsp_valid), 32'd0);
      chk("alt_c3_rd0_hold", 32'(if0.rsp_rdata), 32'hAAAA);
      step();
      no_rsp("alt_c4");
      chk("alt_c4_rd1_hold", 32'(if1.rsp_rdata), 32'h5555);

      drv0(1'b1, 1'b0, 15'h0001, 16'h0000);
      drv1(1'b1, 1'b1, 15'h4001, 16'h0BAD);
      #1;
      chk("rr_rdy0", 32'(if0.ready), 32'd1);
      step();
      reset = 1'b1;
      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      drv1(1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      no_rsp("rr_in_rst");
      chk("rr_rd0_rst", 32'(if0.rsp_rdata), 32'd0);
      chk("rr_rd1_rst", 32'(if1.rsp_rdata), 32'd0);
      step();
      reset = 1'b0;
      #1;
      no_rsp("rr_after");
      chk("rr_after_ld", 32'(mem_load), 32'd0);
      contend(5, "rr_cnt");

      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         drv1(1'b1, 1'b1, 15'(15'h4000 + i), 16'(16'hC000 + i));
         #1;
         chk($sformatf("p1_rdy1_%0d", i), 32'(if1.ready), 32'd1);
         chk($sformatf("p1_ld_%0d", i), 32'(mem_load), 32'd1);
         chk($sformatf("p1_addr_%0d", i), 32'(mem_addr), 32'h4000 + i);
         no_rsp($sformatf("p1_%0d", i));
         step();
      end
      drv1(1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      no_rsp("p1_tail");
      step();
      contend(5, "p1_cnt");

      drv0(1'b0, 1'b0, 15'h0000, 16'h0000);
      drv1(1'b0, 1'b0, 15'h0000, 16'h0000);
      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hack_ram_arbiter.md
Name: hack_ram_arbiter

Overview:
- Shares one single-port Hack data RAM (16-bit words, 15-bit address) between two requesters.
- Port 0 is the CPU data port and has fixed high priority. Port 1 is the screen/DMA reader and has a bounded-starvation guarantee.
- Sits between the CPU/screen logic and the RAM built from Bit/Register cells.
- Issues at most one RAM access per cycle and returns read data one cycle after grant, tagged to the owning port.

Parameters:
- ADDR_W, 15, RAM word address width
- DATA_W, 16, RAM data width
- MAX_WAIT, 4, cycles port 1 may be denied while valid before it is forced to win (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  CPU request present
- req0_ready  out  1  CPU request granted this cycle
- req0_addr  in  ADDR_W  CPU word address
- req0_we  in  1  1 = write, 0 = read
- req0_wdata  in  DATA_W  CPU write data
- rsp0_valid  out  1  CPU read data valid
- rsp0_rdata  out  DATA_W  CPU read data
- req1_valid, req1_ready, req1_addr, req1_we, req1_wdata  same as port 0, for port 1
- rsp1_valid, rsp1_rdata  same as port 0, for port 1
- mem_addr  out  ADDR_W  RAM address
- mem_load  out  1  RAM write enable; write happens at the clk edge
- mem_in  out  DATA_W  RAM write data
- mem_out  in  DATA_W  RAM read data for the address presented in the previous cycle

Behaviour:
- Reset:
  - On a clk edge with reset=1: wait counter = 0, response stage cleared.
  - While reset=1: req*_ready=0, mem_load=0, rsp*_valid=0, rsp*_rdata=0, mem_addr=0, mem_in=0.
  - Reset asserted mid-operation discards any pending read response; no rsp_valid is issued for it.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - req*_ready is combinational from the valid inputs and the wait counter.
  - Requesters must not make valid depend on ready, and must hold addr/we/wdata stable while valid && !ready.
- Arbitration, evaluated every cycle:
  - If starve = (wait_cnt == MAX_WAIT) and req1_valid: grant port 1.
  - Else if req0_valid: grant port 0.
  - Else if req1_valid: grant port 1.
  - Else: no grant.
  - Exactly one ready is high per cycle, at most.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle req1_valid && !req1_ready.
  - Clears to 0 on a port-1 grant, or when req1_valid=0.
- RAM drive:
  - mem_addr, mem_load and mem_in come from the granted port's addr, we and wdata.
  - With no grant: mem_load=0; mem_addr/mem_in hold their last value (don't-care, but never X after reset).
- Response stage:
  - A granted read registers owner id and a pending flag.
  - Next cycle: rsp<owner>_valid=1 for exactly one cycle, and rsp<owner>_rdata = mem_out.
  - Writes produce no response.
  - Latency is 1 cycle from grant to response. Throughput is 1 access/cycle, with back-to-back grants allowed (including alternating owners).
- Read-after-write: a write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data in cycle N+2.
- The non-owner rsp_rdata holds its previous value; rsp_valid is the qualifier.
- Width rules: no arithmetic on data. Wait counter is 4 bits, compared against MAX_WAIT.

Decomposition:
- Shared package (hack_pkg): ADDR_W/DATA_W defaults, owner enum {OWN_CPU=0, OWN_DMA=1}, request struct {addr, we, wdata}.
- One natural sub-module: hack_rr_starve_ctr (saturating wait counter plus starve flag), reusable for later keyboard/DMA arbiters.

Test Plan:
- Reset with both valids high -> both readys 0, mem_load=0, no rsp for 3 cycles. Release -> port 0 granted in the first cycle.
- Port 0 writes 0x1234 @0x0010, then reads @0x0010 next cycle -> mem_load=1 on cycle 1. rsp0_valid=1 with rdata 0x1234 on cycle 3; rsp1_valid never asserts.
- Both valid continuously, MAX_WAIT=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1...; port 1 is never denied more than 4 consecutive cycles.
- Alternating reads: port 0 @0x0001 (holds 0xAAAA) and port 1 @0x4000 (holds 0x5555) in consecutive cycles -> rsp0 0xAAAA, then rsp1 0x5555 the following cycle, each valid for exactly 1 cycle.
- Read granted, then reset asserted the next cycle -> no rsp_valid; wait counter reads 0 after reset.
- Only port 1 valid, with writes to 0x4000..0x4003 -> ready1=1 every cycle, four mem_load pulses, no responses, wait counter stays 0.
